// File: rtl/apb2_cmd_master.sv
// ---------------------------------------------------------------------------
// apb2_cmd_master
//
// APB2 initiator. Each accepted single-beat command becomes one APB
// SETUP + ACCESS transfer on the shared bus. Every command gets exactly one
// response, which carries read data, a slave error or a timeout.
//
// Ports
//   pclk, prst       bus clock (rising edge), asynchronous active-high reset
//   cmd_*            command channel (valid/ready); fields are captured on accept
//   rsp_*            response channel; rsp_valid is a one-cycle pulse and the
//                    data/flags hold until the next response
//   psel..pprot      APB initiator outputs, all registered
//   prdata, pready,
//   pslverr          per-slave APB returns; slave i's data is at
//                    prdata[i*DATA_W +: DATA_W]
//
// State table
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | cmd_ready=1, waiting for cmd_valid
//   ST_SETUP  | psel asserted, penable=0, one cycle
//   ST_ACCESS | penable=1, waiting for pready of the selected slave or timeout
//   ST_RESP   | rsp_valid=1 for one cycle, then back to idle
// ---------------------------------------------------------------------------
module apb2_cmd_master #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int NUM_SEL     = 2,
    parameter int TIMEOUT_CYC = 255,
    localparam int SEL_W      = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1,
    localparam int STRB_W     = DATA_W / 8
) (
    input  logic                      pclk,
    input  logic                      prst,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [SEL_W-1:0]          cmd_sel,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]         cmd_wdata,
    input  logic [STRB_W-1:0]         cmd_strb,
    input  logic [2:0]                cmd_prot,

    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,

    output logic [NUM_SEL-1:0]        psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    output logic [STRB_W-1:0]         pstrb,
    output logic [2:0]                pprot,
    input  logic [NUM_SEL*DATA_W-1:0] prdata,
    input  logic [NUM_SEL-1:0]        pready,
    input  logic [NUM_SEL-1:0]        pslverr
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam int  TCNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit  TMO_EN = (TIMEOUT_CYC != 0);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC);

    logic [1:0]        state;
    logic [TCNT_W-1:0] tcnt;

    // Decode of the incoming select: one-hot plus an in-range flag. Written
    // as a loop so a non-power-of-two NUM_SEL needs no separate compare.
    logic [NUM_SEL-1:0] sel_onehot;
    logic               sel_in_range;

    always_comb begin
        sel_onehot   = '0;
        sel_in_range = 1'b0;
        for (int i = 0; i < NUM_SEL; i++) begin
            if (cmd_sel == SEL_W'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_in_range  = 1'b1;
            end
        end
    end

    // Return path is muxed by the registered psel, so only the addressed
    // slave can complete or fail a transfer; other slaves' lines are ignored.
    logic              pready_sel;
    logic              pslverr_sel;
    logic [DATA_W-1:0] prdata_sel;

    always_comb begin
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        prdata_sel  = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            if (psel[i]) begin
                pready_sel  = pready[i];
                pslverr_sel = pslverr[i];
                prdata_sel  = prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    logic tmo_hit;
    assign tmo_hit = TMO_EN && (tcnt == TCNT_LAST);

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state       <= ST_IDLE;
            tcnt        <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            psel        <= '0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            pprot       <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (sel_in_range) begin
                            state   <= ST_SETUP;
                            psel    <= sel_onehot;
                            penable <= 1'b0;
                            pwrite  <= cmd_write;
                            paddr   <= cmd_addr;
                            pwdata  <= cmd_wdata;
                            pstrb   <= cmd_write ? cmd_strb : '0;
                            pprot   <= cmd_prot;
                            tcnt    <= '0;
                        end else begin
                            // Nobody to talk to: answer with an error and
                            // leave the bus untouched.
                            state       <= ST_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_rdata   <= '0;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                        end
                    end
                end

                ST_SETUP: begin
                    state   <= ST_ACCESS;
                    penable <= 1'b1;
                end

                ST_ACCESS: begin
                    if (pready_sel) begin
                        state       <= ST_RESP;
                        psel        <= '0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslverr_sel;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (!pwrite && !pslverr_sel) ? prdata_sel : '0;
                    end else if (tmo_hit) begin
                        // Counter already holds TIMEOUT_CYC waited cycles,
                        // so this is ACCESS cycle TIMEOUT_CYC+1: give up.
                        state       <= ST_RESP;
                        psel        <= '0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end else if (TMO_EN) begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end

                ST_RESP: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end

                default: begin
                    state     <= ST_IDLE;
                    psel      <= '0;
                    penable   <= 1'b0;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    // Bus protocol invariants.
    a_psel_onehot0: assert property (@(posedge pclk) disable iff (prst)
        $onehot0(psel));
    a_penable_needs_psel: assert property (@(posedge pclk) disable iff (prst)
        penable |-> (psel != '0));
    a_rsp_single_pulse: assert property (@(posedge pclk) disable iff (prst)
        rsp_valid |=> !rsp_valid);

endmodule

// File: tb/tb_apb2_cmd_master.sv
// ---------------------------------------------------------------------------
// Bench for apb2_cmd_master, built with NUM_SEL=3 (so sel=3 is out of range)
// and TIMEOUT_CYC=4. Stimulus pushes expected bus transfers and responses
// into queues; monitors on the falling edge pop and compare.
// ---------------------------------------------------------------------------
module tb_apb2_cmd_master;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int NUM_SEL = 3;
    localparam int TMO     = 4;

    logic        pclk = 1'b0;
    logic        prst = 1'b1;
    always #5 pclk = ~pclk;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_sel;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [2:0]  psel;
    logic        penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [95:0] prdata;
    logic [2:0]  pready, pslverr;

    apb2_cmd_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SEL(NUM_SEL), .TIMEOUT_CYC(TMO)
    ) dut (
        .pclk(pclk), .prst(prst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Slave models: selected slave answers after s_wait ACCESS cycles;
    // unselected slaves drive ready/error high to expose a wrong mux.
    int          s_wait  [3];
    logic        s_err   [3];
    logic        s_stuck [3];
    logic [31:0] s_rdata [3];
    int          acc_cyc;
    int          cyc = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    always @(posedge pclk or posedge prst) begin
        if (prst)                      acc_cyc <= 0;
        else if (psel != 0 && penable) acc_cyc <= acc_cyc + 1;
        else                           acc_cyc <= 0;
    end

    always_comb begin
        pready  = '0;
        pslverr = '0;
        prdata  = '0;
        for (int i = 0; i < 3; i++) begin
            if (psel[i]) begin
                pready[i]  = penable && (acc_cyc >= s_wait[i]) && !s_stuck[i];
                pslverr[i] = penable && (acc_cyc >= s_wait[i]) && !s_stuck[i] && s_err[i];
            end else begin
                pready[i]  = 1'b1;
                pslverr[i] = 1'b1;
            end
            prdata[i*32 +: 32] = s_rdata[i];
        end
    end

    typedef struct {
        int          sel;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          len;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          lat;
    } rsp_t;

    bus_t exp_bus[$];
    rsp_t exp_rsp[$];
    int   acc_q[$];
    int   accept_cnt = 0;

    // Monitor: accepts, responses and bus phases, all sampled on negedge.
    initial begin : monitor
        int          prev, cur, len, a;
        logic        expect_ready, unstable;
        logic [2:0]  s_psel;
        logic        s_wr;
        logic [7:0]  s_addr;
        logic [31:0] s_wd;
        logic [3:0]  s_st;
        logic [2:0]  s_pr;
        bus_t        b;
        rsp_t        r;
        prev = 0; len = 0; expect_ready = 1'b0; unstable = 1'b0;
        s_psel = '0; s_wr = 1'b0; s_addr = '0; s_wd = '0; s_st = '0; s_pr = '0;
        forever begin
            @(negedge pclk);
            if (prst) begin
                prev = 0;
                expect_ready = 1'b0;
                acc_q.delete();
            end else begin
                if (cmd_valid && cmd_ready) begin
                    acc_q.push_back(cyc);
                    accept_cnt++;
                end
                if (expect_ready) begin
                    chk("ready_after_rsp", cmd_ready, 1);
                    expect_ready = 1'b0;
                end
                if (rsp_valid) begin
                    if (exp_rsp.size() == 0) begin
                        chk("rsp_unexpected", 1, 0);
                    end else begin
                        r = exp_rsp.pop_front();
                        chk("rsp_rdata", rsp_rdata, r.rdata);
                        chk("rsp_err", rsp_err, r.err);
                        chk("rsp_timeout", rsp_timeout, r.tmo);
                        if (acc_q.size() == 0) begin
                            chk("rsp_without_accept", 1, 0);
                        end else begin
                            a = acc_q.pop_front();
                            chk("rsp_latency", cyc - a, r.lat);
                        end
                        expect_ready = 1'b1;
                    end
                end

                cur = (psel == 0) ? 0 : (penable ? 2 : 1);
                chk("psel_onehot0", ($countones(psel) <= 1), 1);
                chk("penable_without_psel", (penable && psel == 0), 0);
                chk("ready_while_busy", (cmd_ready && psel != 0), 0);
                chk("access_without_setup", (cur == 2 && prev == 0), 0);
                chk("setup_longer_than_1", (cur == 1 && prev == 1), 0);
                if (cur == 1) begin
                    s_psel = psel; s_wr = pwrite; s_addr = paddr;
                    s_wd = pwdata; s_st = pstrb; s_pr = pprot;
                    len = 0; unstable = 1'b0;
                end
                if (cur == 2) begin
                    len++;
                    if (psel !== s_psel || pwrite !== s_wr || paddr !== s_addr ||
                        pwdata !== s_wd || pstrb !== s_st || pprot !== s_pr)
                        unstable = 1'b1;
                end
                if (prev == 2 && cur != 2) begin
                    chk("bus_idle_after_access", cur, 0);
                    if (exp_bus.size() == 0) begin
                        chk("bus_unexpected", 1, 0);
                    end else begin
                        b = exp_bus.pop_front();
                        chk("bus_psel", s_psel, (3'b001 << b.sel));
                        chk("bus_pwrite", s_wr, b.wr);
                        chk("bus_paddr", s_addr, b.addr);
                        chk("bus_pwdata", s_wd, b.wdata);
                        chk("bus_pstrb", s_st, b.strb);
                        chk("bus_pprot", s_pr, b.prot);
                        chk("bus_access_len", len, b.len);
                        chk("bus_stable", unstable, 0);
                    end
                end
                prev = cur;
            end
        end
    end

    // Issue one command. blen=0 means no bus transfer is expected.
    task automatic send(input logic wr, input logic [1:0] sel, input logic [7:0] addr,
                        input logic [31:0] wd, input logic [3:0] st, input logic [2:0] prot,
                        input logic hold, input logic expect_it, input int blen,
                        input logic [31:0] erd, input logic eerr, input logic etmo,
                        input int lat);
        bus_t b;
        rsp_t r;
        int   n;
        cmd_write = wr; cmd_sel = sel; cmd_addr = addr;
        cmd_wdata = wd; cmd_strb = st; cmd_prot = prot;
        cmd_valid = 1'b1;
        if (expect_it) begin
            if (blen > 0) begin
                b.sel = int'(sel); b.wr = wr; b.addr = addr; b.wdata = wd;
                b.strb = wr ? st : 4'h0; b.prot = prot; b.len = blen;
                exp_bus.push_back(b);
            end
            r.rdata = erd; r.err = eerr; r.tmo = etmo; r.lat = lat;
            exp_rsp.push_back(r);
        end
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(posedge pclk); #1;
            n++;
        end
        chk("cmd_accept_wait", (n < 50), 1);
        @(posedge pclk); #1;
        if (!hold) begin
            cmd_valid = 1'b0;
            cmd_write = ~wr; cmd_sel = 2'd2; cmd_addr = 8'hFF;
            cmd_wdata = 32'hFFFF_FFFF; cmd_strb = 4'h0; cmd_prot = 3'h7;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || exp_bus.size() != 0) && n < 100) begin
            @(posedge pclk); #1;
            n++;
        end
        chk("drain_wait", (n < 100), 1);
        repeat (2) begin @(posedge pclk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin : stim
        int a0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_sel = '0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
        for (int i = 0; i < 3; i++) begin
            s_wait[i] = 0; s_err[i] = 1'b0; s_stuck[i] = 1'b0;
        end
        s_rdata[0] = 32'h1111_1111; s_rdata[1] = 32'h2222_2222; s_rdata[2] = 32'h3333_3333;

        prst = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_psel", psel, 0);
        chk("reset_penable", penable, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_paddr", paddr, 0);
        chk("reset_pwdata", pwdata, 0);
        chk("reset_pstrb", pstrb, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_flags", {rsp_err, rsp_timeout}, 0);
        prst = 1'b0;
        @(posedge pclk); #1;
        chk("ready_after_reset", cmd_ready, 1);

        // Zero-wait write to slave 0
        send(1'b1, 2'd0, 8'h04, 32'hDEAD_BEEF, 4'hF, 3'd0, 1'b0, 1'b1, 1,
             32'h0, 1'b0, 1'b0, 3);
        wait_done();

        // Read slave 1 with 3 wait states; strobes forced to 0
        s_wait[1] = 3; s_rdata[1] = 32'h1234_5678;
        send(1'b0, 2'd1, 8'h10, 32'h55AA_55AA, 4'hF, 3'b010, 1'b0, 1'b1, 4,
             32'h1234_5678, 1'b0, 1'b0, 6);
        wait_done();

        // Read with slave error
        s_wait[0] = 1; s_err[0] = 1'b1; s_rdata[0] = 32'hAAAA_5555;
        send(1'b0, 2'd0, 8'h08, 32'h0, 4'h0, 3'd0, 1'b0, 1'b1, 2,
             32'h0, 1'b1, 1'b0, 4);
        wait_done();
        s_err[0] = 1'b0; s_wait[0] = 0;

        // Timeout: pready stuck low on slave 1
        s_stuck[1] = 1'b1;
        send(1'b0, 2'd1, 8'h20, 32'h0, 4'h0, 3'd1, 1'b0, 1'b1, 5,
             32'h0, 1'b0, 1'b1, 7);
        wait_done();
        s_stuck[1] = 1'b0; s_wait[1] = 0; s_rdata[1] = 32'hCAFE_F00D;
        send(1'b0, 2'd1, 8'h24, 32'h0, 4'h0, 3'd0, 1'b0, 1'b1, 1,
             32'hCAFE_F00D, 1'b0, 1'b0, 3);
        wait_done();

        // Out-of-range select: no bus activity, error response
        send(1'b1, 2'd3, 8'h50, 32'h0000_1234, 4'hF, 3'd0, 1'b0, 1'b1, 0,
             32'h0, 1'b1, 1'b0, 1);
        wait_done();

        // Back-to-back with cmd_valid held high
        s_wait[2] = 2; s_rdata[2] = 32'h0BAD_C0DE;
        a0 = accept_cnt;
        send(1'b1, 2'd0, 8'h30, 32'h0102_0304, 4'h3, 3'b001, 1'b1, 1'b1, 1,
             32'h0, 1'b0, 1'b0, 3);
        send(1'b0, 2'd2, 8'h34, 32'h0, 4'hF, 3'b100, 1'b1, 1'b1, 3,
             32'h0BAD_C0DE, 1'b0, 1'b0, 5);
        send(1'b1, 2'd1, 8'h38, 32'hA5A5_A5A5, 4'hC, 3'd0, 1'b0, 1'b1, 1,
             32'h0, 1'b0, 1'b0, 3);
        wait_done();
        chk("b2b_accept_count", accept_cnt - a0, 3);

        // Reset in the middle of ACCESS: bus drops at once, no response
        s_wait[0] = 5;
        send(1'b0, 2'd0, 8'h60, 32'h0, 4'h0, 3'd0, 1'b0, 1'b0, 0,
             32'h0, 1'b0, 1'b0, 0);
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        chk("pre_reset_in_access", {psel, penable}, {3'b001, 1'b1});
        #2;
        prst = 1'b1;
        #1;
        chk("mid_reset_psel", psel, 0);
        chk("mid_reset_penable", penable, 0);
        chk("mid_reset_rsp_valid", rsp_valid, 0);
        chk("mid_reset_cmd_ready", cmd_ready, 0);
        @(posedge pclk);
        @(posedge pclk); #1;
        prst = 1'b0;
        s_wait[0] = 0;
        repeat (6) begin @(posedge pclk); #1; end
        send(1'b1, 2'd1, 8'h40, 32'h0000_0077, 4'hF, 3'd0, 1'b0, 1'b1, 1,
             32'h0, 1'b0, 1'b0, 3);
        wait_done();

        chk("rsp_queue_empty", exp_rsp.size(), 0);
        chk("bus_queue_empty", exp_bus.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
